// File: rtl/ctr_load_sched.sv
// ---------------------------------------------------------------------------
// ctr_load_sched
//
// Controller for a cascade of STAGES 74161-style 4-bit synchronous counters.
// It sequences the count enables of the video timing chain, forces modulo-N
// operation by reloading wrap_val at terminal count, and arbitrates the single
// parallel-load port between that periodic wrap reload and a host preset.
//
// Parameters
//   STAGES  number of cascaded 4-bit stages (data width W = 4*STAGES)
//   WCNT_W  width of the wrap event counter
//
// Ports
//   cp          clock, rising edge
//   mr          asynchronous active-high reset
//   run         level, 1 = chain should count
//   tc_in       terminal count of the last stage (already gated by cet)
//   wrap_val    start value reloaded at each wrap
//   host_req    host load request (level)
//   host_val    value loaded for the host, sampled at acceptance
//   host_ack    pulse: the host load happens on this cycle's edge
//   pe_n        parallel-load enable to all stages, active low
//   p           parallel data, nibble k drives stage k
//   cep, cet    count enables (parallel / trickle into stage 0)
//   wrap_pulse  pulse on each wrap reload
//   wrap_cnt    wraps since reset, rolls over
//   busy        high while a host load is loading or settling
//
// Build option
//   CTR_LOAD_SCHED_ONESHOT_EN: when defined, each wrap parks the chain at
//   wrap_val in ONESHOT_STOP until run is toggled 0->1. When undefined the
//   chain wraps continuously and ONESHOT_STOP does not exist.
// ---------------------------------------------------------------------------
module ctr_load_sched #(
  parameter  int STAGES = 2,
  parameter  int WCNT_W = 8,
  localparam int W      = 4 * STAGES
) (
  input  logic              cp,
  input  logic              mr,
  input  logic              run,
  input  logic              tc_in,
  input  logic [W-1:0]      wrap_val,
  input  logic              host_req,
  input  logic [W-1:0]      host_val,
  output logic              host_ack,
  output logic              pe_n,
  output logic [W-1:0]      p,
  output logic              cep,
  output logic              cet,
  output logic              wrap_pulse,
  output logic [WCNT_W-1:0] wrap_cnt,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_HLOAD,
    S_SETTLE
`ifdef CTR_LOAD_SCHED_ONESHOT_EN
    , S_ONESHOT_STOP
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [W-1:0]      host_val_q, host_val_d;
  logic              armed_q, armed_d;
  logic [WCNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              accept;
  logic              wrap;
`ifdef CTR_LOAD_SCHED_ONESHOT_EN
  // Remembers that a host load was taken from ONESHOT_STOP so SETTLE can
  // return there instead of starting a new sweep.
  logic              from_stop_q, from_stop_d;
`endif

  // A wrap only happens while the chain is actually enabled (RUN).
  assign wrap = (state_q == S_RUN) && tc_in;

  // Host requests are only taken from the resting/counting states, and only
  // once per request assertion (armed re-sets when host_req drops).
`ifdef CTR_LOAD_SCHED_ONESHOT_EN
  assign accept = host_req && armed_q &&
                  ((state_q == S_IDLE) || (state_q == S_RUN) ||
                   (state_q == S_ONESHOT_STOP));
`else
  assign accept = host_req && armed_q &&
                  ((state_q == S_IDLE) || (state_q == S_RUN));
`endif

  // NOTE: every variable assigned in an always_comb gets a default first, so
  // no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    host_val_d = host_val_q;
    armed_d    = armed_q;
    wrap_cnt_d = wrap_cnt_q;
`ifdef CTR_LOAD_SCHED_ONESHOT_EN
    from_stop_d = from_stop_q;
`endif

    if (!host_req) armed_d = 1'b1;
    if (wrap)      wrap_cnt_d = wrap_cnt_q + WCNT_W'(1);

    if (accept) begin
      // Host acceptance wins over run-driven transitions on the same edge.
      host_val_d = host_val;
      armed_d    = 1'b0;
      state_d    = S_HLOAD;
`ifdef CTR_LOAD_SCHED_ONESHOT_EN
      from_stop_d = (state_q == S_ONESHOT_STOP);
`endif
    end else begin
      case (state_q)
        S_IDLE:   if (run) state_d = S_RUN;
        S_RUN: begin
          if (!run) state_d = S_IDLE;
`ifdef CTR_LOAD_SCHED_ONESHOT_EN
          else if (wrap) state_d = S_ONESHOT_STOP;
`endif
        end
        S_HLOAD:  state_d = S_SETTLE;
        S_SETTLE: begin
          if (!run) state_d = S_IDLE;
`ifdef CTR_LOAD_SCHED_ONESHOT_EN
          else if (from_stop_q) state_d = S_ONESHOT_STOP;
`endif
          else state_d = S_RUN;
        end
`ifdef CTR_LOAD_SCHED_ONESHOT_EN
        S_ONESHOT_STOP: if (!run) state_d = S_IDLE;
`endif
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge cp or posedge mr) begin
    if (mr) begin
      state_q    <= S_IDLE;
      host_val_q <= '0;
      armed_q    <= 1'b1;
      wrap_cnt_q <= '0;
`ifdef CTR_LOAD_SCHED_ONESHOT_EN
      from_stop_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      host_val_q <= host_val_d;
      armed_q    <= armed_d;
      wrap_cnt_q <= wrap_cnt_d;
`ifdef CTR_LOAD_SCHED_ONESHOT_EN
      from_stop_q <= from_stop_d;
`endif
    end
  end

  // Outputs are decoded from the current state, so an asynchronous reset
  // drops the enables and the load strobe immediately.
  always_comb begin
    cep        = (state_q == S_RUN);
    cet        = (state_q == S_RUN);
    busy       = (state_q == S_HLOAD) || (state_q == S_SETTLE);
    pe_n       = 1'b1;
    p          = wrap_val;
    host_ack   = 1'b0;
    wrap_pulse = 1'b0;
    if (state_q == S_HLOAD) begin
      pe_n     = 1'b0;
      p        = host_val_q;
      host_ack = 1'b1;
    end else if (wrap) begin
      pe_n       = 1'b0;
      wrap_pulse = 1'b1;
    end
  end

  assign wrap_cnt = wrap_cnt_q;

endmodule

// File: tb/tb_ctr_load_sched.sv
// ---------------------------------------------------------------------------
// tb_ctr_load_sched
//
// Drives ctr_load_sched with a two-stage 74161 chain model (STAGES=2) and
// compares its outputs against fixed vectors, hand-written corner sequences
// and an event-level model of the load scheduler. Build option
// CTR_LOAD_SCHED_ONESHOT_EN selects the one-shot expectations.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ctr_load_sched;
  localparam int W      = 8;
  localparam int WCNT_W = 8;
`ifdef CTR_LOAD_SCHED_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  logic              cp = 1'b0;
  logic              mr, run, tc_in, host_req;
  logic [W-1:0]      wrap_val, host_val;
  logic              host_ack, pe_n, cep, cet, wrap_pulse, busy;
  logic [W-1:0]      p;
  logic [WCNT_W-1:0] wrap_cnt;

  int n_vec = 0;
  int n_err = 0;

  ctr_load_sched #(.STAGES(2), .WCNT_W(WCNT_W)) dut (
    .cp(cp), .mr(mr), .run(run), .tc_in(tc_in), .wrap_val(wrap_val),
    .host_req(host_req), .host_val(host_val), .host_ack(host_ack),
    .pe_n(pe_n), .p(p), .cep(cep), .cet(cet), .wrap_pulse(wrap_pulse),
    .wrap_cnt(wrap_cnt), .busy(busy)
  );

  always #5 cp = ~cp;

  // Two chained 74161 stages: stage 1's cet is stage 0's ripple carry.
  logic [3:0] q0, q1;
  logic       tc0, chain_preset;
  logic [7:0] chain;
  assign tc0   = cet && (q0 == 4'hF);
  assign tc_in = tc0 && (q1 == 4'hF);
  assign chain = {q1, q0};

  always @(posedge cp) begin
    if (chain_preset) begin
      q1 <= 4'hF;
      q0 <= 4'h0;
    end else if (!pe_n) begin
      q1 <= p[7:4];
      q0 <= p[3:0];
    end else begin
      if (cep && cet) q0 <= q0 + 4'd1;
      if (cep && tc0) q1 <= q1 + 4'd1;
    end
  end

  // Event-level reference: what the chain should hold and which load or
  // count event each cycle should produce.
  logic       m_counting, m_stopped, m_ret_stop, m_armed;
  int         m_load_left;  // 2 = host load this cycle, 1 = settling
  logic [7:0] m_hv, m_chain;
  int         m_wraps;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_counting = 1'b0; m_stopped = 1'b0; m_ret_stop = 1'b0; m_armed = 1'b1;
    m_load_left = 0; m_hv = 8'h00; m_wraps = 0;
  endtask

  // One clock: check outputs against the model at the falling edge, advance
  // the model, then return #1 after the rising edge.
  task automatic step();
    logic e_ack, e_cep, e_wrap, e_busy, acc;
    logic [7:0] e_p;
    @(negedge cp);
    e_ack  = (m_load_left == 2);
    e_busy = (m_load_left != 0);
    e_cep  = m_counting && !m_stopped && (m_load_left == 0);
    e_wrap = e_cep && (m_chain == 8'hFF);
    e_p    = e_ack ? m_hv : wrap_val;
    check("chain", 32'(chain), 32'(m_chain));
    check("outputs", 32'({cep, cet, pe_n, host_ack, wrap_pulse, busy, p, wrap_cnt}),
          32'({e_cep, e_cep, !(e_ack || e_wrap), e_ack, e_wrap, e_busy, e_p, 8'(m_wraps)}));
    acc = (m_load_left == 0) && host_req && m_armed;
    if (e_ack)       m_chain = m_hv;
    else if (e_wrap) m_chain = wrap_val;
    else if (e_cep)  m_chain = m_chain + 8'd1;
    if (e_wrap) m_wraps++;
    if (m_load_left > 0) begin
      m_load_left--;
      if (m_load_left == 0) begin
        m_counting = run;
        m_stopped  = run && m_ret_stop;
      end
    end else if (acc) begin
      m_load_left = 2;
      m_hv        = host_val;
      m_armed     = 1'b0;
      m_ret_stop  = m_stopped;
    end else if (!run) begin
      m_counting = 1'b0;
      m_stopped  = 1'b0;
    end else begin
      if (ONESHOT && e_wrap) m_stopped = 1'b1;
      m_counting = 1'b1;
    end
    if (!host_req) m_armed = 1'b1;
    @(posedge cp);
    #1;
  endtask

  task automatic do_reset();
    mr = 1'b1; chain_preset = 1'b1; run = 1'b0; host_req = 1'b0; host_val = 8'h00;
    wrap_val = 8'hF0;
    @(posedge cp); #1;
    check("reset_outputs", 32'({cep, cet, pe_n, host_ack, wrap_pulse, busy, p, wrap_cnt}),
          32'({6'b001000, 8'hF0, 8'h00}));
    @(posedge cp); #1;
    chain_preset = 1'b0; mr = 1'b0;
    model_reset();
    m_chain = 8'hF0;
  endtask

  task automatic run_until(input logic [7:0] target, input string name);
    int k = 0;
    while (chain !== target && k < 300) begin
      step();
      k++;
    end
    check(name, 32'(chain), 32'(target));
  endtask

  typedef struct {
    logic       run;
    logic       req;
    logic [7:0] hv;
    logic [5:0] e_out;   // {cep, cet, pe_n, host_ack, wrap_pulse, busy}
    logic [7:0] e_p;
    logic [7:0] e_chain; // chain value after this cycle's edge
  } vec_t;

  vec_t tbl[16];
  int   wraps_before;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Held host request loads once; run drop/resume; second load after re-arm.
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 6'b001000, 8'hF0, 8'hF0};
    tbl[1]  = '{1'b1, 1'b0, 8'h00, 6'b111000, 8'hF0, 8'hF1};
    tbl[2]  = '{1'b1, 1'b1, 8'h3C, 6'b111000, 8'hF0, 8'hF2};
    tbl[3]  = '{1'b1, 1'b1, 8'h55, 6'b000101, 8'h3C, 8'h3C};
    tbl[4]  = '{1'b1, 1'b1, 8'h55, 6'b001001, 8'hF0, 8'h3C};
    tbl[5]  = '{1'b1, 1'b1, 8'h55, 6'b111000, 8'hF0, 8'h3D};
    tbl[6]  = '{1'b1, 1'b1, 8'h55, 6'b111000, 8'hF0, 8'h3E};
    tbl[7]  = '{1'b1, 1'b0, 8'h55, 6'b111000, 8'hF0, 8'h3F};
    tbl[8]  = '{1'b0, 1'b0, 8'h55, 6'b111000, 8'hF0, 8'h40};
    tbl[9]  = '{1'b0, 1'b0, 8'h55, 6'b001000, 8'hF0, 8'h40};
    tbl[10] = '{1'b1, 1'b0, 8'h55, 6'b001000, 8'hF0, 8'h40};
    tbl[11] = '{1'b1, 1'b0, 8'h55, 6'b111000, 8'hF0, 8'h41};
    tbl[12] = '{1'b1, 1'b1, 8'hA5, 6'b111000, 8'hF0, 8'h42};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 6'b000101, 8'hA5, 8'hA5};
    tbl[14] = '{1'b0, 1'b0, 8'h00, 6'b001001, 8'hF0, 8'hA5};
    tbl[15] = '{1'b0, 1'b0, 8'h00, 6'b001000, 8'hF0, 8'hA5};

    do_reset();
    for (int i = 0; i < 16; i++) begin
      run = tbl[i].run; host_req = tbl[i].req; host_val = tbl[i].hv;
      @(negedge cp);
      check($sformatf("vec%0d_out", i), 32'({cep, cet, pe_n, host_ack, wrap_pulse, busy}),
            32'(tbl[i].e_out));
      check($sformatf("vec%0d_p", i), 32'(p), 32'(tbl[i].e_p));
      @(posedge cp); #1;
      check($sformatf("vec%0d_chain", i), 32'(chain), 32'(tbl[i].e_chain));
    end

`ifndef CTR_LOAD_SCHED_ONESHOT_EN
    // Continuous modulo-16 count: enables one cycle after run, two wraps.
    do_reset();
    run = 1'b1;
    step();
    check("s1_first_cep", 32'(cep), 32'd1);
    for (int i = 1; i < 40; i++) step();
    check("s1_wrap_cnt", 32'(wrap_cnt), 32'd2);

    // Host acceptance on the wrap edge: F0 first, then 3C.
    run_until(8'hFF, "s3_reach_ff");
    host_req = 1'b1; host_val = 8'h3C;
    wraps_before = m_wraps;
    step();
    check("s3_wrap_load", 32'(chain), 32'hF0);
    check("s3_ack_now", 32'(host_ack), 32'd1);
    step();
    check("s3_host_load", 32'(chain), 32'h3C);
    check("s3_wrap_cnt", 32'(wrap_cnt), 32'(8'(wraps_before + 1)));
    host_req = 1'b0;
    step();

    // Pause at F7, resume at F8 one cycle after run returns.
    run_until(8'hF6, "s5_reach_f6");
    run = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      check("s5_hold", 32'({chain, pe_n}), 32'({8'hF7, 1'b1}));
    end
    run = 1'b1;
    step();
    check("s5_resume_delay", 32'(chain), 32'hF7);
    step();
    check("s5_resume", 32'(chain), 32'hF8);

    // wrap_val=FF wraps every cycle: 284 wraps roll the counter to 28.
    do_reset();
    wrap_val = 8'hFF; run = 1'b1;
    for (int i = 0; i < 300; i++) step();
    check("rollover_wrap_cnt", 32'(wrap_cnt), 32'd28);
`else
    // One sweep, rest at F0, then a second sweep after a run toggle.
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 40; i++) step();
    check("s6_rest", 32'({chain, cep, pe_n}), 32'({8'hF0, 1'b0, 1'b1}));
    check("s6_one_wrap", 32'(wrap_cnt), 32'd1);
    run = 1'b0;
    step();
    run = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("s6_second_sweep", 32'(wrap_cnt), 32'd2);
    check("s6_rest2", 32'({chain, cep}), 32'({8'hF0, 1'b0}));
`endif

    // Asynchronous reset in the middle of a host load.
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 20; i++) step();
    host_req = 1'b1; host_val = 8'h3C;
    step();
    @(negedge cp);
    check("s4_in_hload", 32'(host_ack), 32'd1);
    #1 mr = 1'b1;
    #1 check("s4_async_reset", 32'({pe_n, cep, host_ack, busy, wrap_cnt}),
             32'({4'b1000, 8'h00}));
    #1 mr = 1'b0; host_req = 1'b0; run = 1'b0;
    model_reset();
    @(posedge cp); #1;
    step();

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      run = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 5) == 0) host_req = ~host_req;
      host_val = 8'($urandom);
      if ($urandom_range(0, 40) == 0) begin
        case ($urandom_range(0, 3))
          0:       wrap_val = 8'hF0;
          1:       wrap_val = 8'hFF;
          2:       wrap_val = 8'hE0;
          default: wrap_val = 8'($urandom_range(8'hD0, 8'hFF));
        endcase
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ctr_load_sched.md
Name: ctr_load_sched

Overview:
Controller for a cascade of STAGES chained 74161-style 4-bit synchronous counters used in the video terminal timing chain.
- Sequences the chain's count enables.
- Forces modulo-N operation by reloading a programmable start value at terminal count.
- Shares the single parallel-load port between that periodic wrap reload and a host load requester (cursor or raster preset).
- Sits between the timing or host logic and the counter chain's pe_n/p/cep/cet pins.

Parameters:
STAGES, 2, number of cascaded 4-bit counter stages; the data width is W = 4*STAGES.
WCNT_W, 8, width of the wrap event counter.

Ports:
cp  input  1  clock, rising edge.
mr  input  1  reset; one clock, reset asynchronous and active-high.
run  input  1  level; 1 = chain should count.
tc_in  input  1  terminal count from the last stage of the chain, already gated by cet.
wrap_val  input  W  start value loaded at wrap.
host_req  input  1  host load request, level.
host_val  input  W  value to load for the host.
host_ack  output  1  one-cycle pulse; the host load is occurring on this cycle's edge.
pe_n  output  1  parallel-load enable to all stages, active low.
p  output  W  parallel data to the stages; nibble k drives stage k.
cep  output  1  count enable (parallel) to all stages.
cet  output  1  count enable (trickle) to stage 0.
wrap_pulse  output  1  one-cycle pulse on each wrap reload.
wrap_cnt  output  WCNT_W  number of wraps since reset.
busy  output  1  high in HLOAD and SETTLE.

Behaviour:
- FSM states:
  - IDLE
  - RUN
  - HLOAD: one cycle, load is performed.
  - SETTLE: one cycle, enables held low after the load.
  - ONESHOT_STOP: used only with the optional feature.
- Reset (mr=1, asynchronous):
  - state=IDLE, host_val_reg=0, armed=1, wrap_cnt=0.
  - Outputs: pe_n=1, cep=0, cet=0, host_ack=0, wrap_pulse=0, busy=0, p=wrap_val.
  - If mr asserts mid-HLOAD, the load is abandoned and no ack is issued.
- Transitions, evaluated on each cp rising edge:
  - IDLE->RUN when run=1.
  - RUN->IDLE when run=0.
  - Host acceptance: in IDLE or RUN, if host_req=1 and armed=1, latch host_val into host_val_reg, clear armed, go to HLOAD.
  - Host acceptance has priority over the run transition on the same edge.
  - HLOAD->SETTLE unconditionally.
  - SETTLE->RUN if run=1, else SETTLE->IDLE.
  - armed sets again on any edge where host_req=0. This prevents a double load while the host holds the request high.
- Outputs, combinational from state and inputs:
  - cep = cet = (state==RUN). Counting therefore starts 1 cycle after run rises.
  - wrap = (state==RUN) & tc_in.
  - In HLOAD: pe_n=0, p=host_val_reg, host_ack=1.
  - Else if wrap: pe_n=0, p=wrap_val, wrap_pulse=1.
  - Otherwise pe_n=1 and p=wrap_val.
- Modulo rule: the chain counts wrap_val .. 2^W-1, then reloads wrap_val. Period = 2^W - wrap_val cycles; wrap_val=0 gives the natural 2^W period.
- Simultaneous host acceptance and wrap: the wrap reload happens on that edge (state still RUN), then HLOAD overwrites it on the next edge. Both events count.
- While in HLOAD, cep=0, so tc_in is ignored and no wrap can occur.
- wrap_cnt increments on each wrap edge and wraps from 2^WCNT_W-1 to 0.
- wrap_val changes take effect at the next wrap with no latching.
- host_val is sampled only at acceptance.

Optional Feature:
CTR_LOAD_SCHED_ONESHOT_EN.
- Defined:
  - A wrap in RUN moves the FSM to ONESHOT_STOP (cep=cet=0, pe_n=1). The chain rests at wrap_val.
  - ONESHOT_STOP->IDLE when run=0, so a new sweep needs a run 0->1 toggle.
  - Host loads are still accepted in ONESHOT_STOP. After SETTLE, the FSM returns to ONESHOT_STOP if run=1.
- Undefined:
  - The ONESHOT_STOP state does not exist and wraps are continuous.

Test Plan:
All scenarios use STAGES=2, wrap_val=8'hF0, and two chained 74161-model stages driven by the DUT.
1. Reset, then run=1 held for 40 cycles -> first cep=1 one cycle after run; count sequence F0..FF repeats with period 16; wrap_pulse at each FF->F0; wrap_cnt=2 after 2 wraps.
2. host_val=8'h3C, host_req held high for 5 cycles during RUN -> exactly one host_ack pulse; chain shows 3C after the HLOAD edge, held 1 cycle in SETTLE, then 3D, 3E...; no second load until host_req drops and rises again.
3. Host acceptance on the same edge where chain=FF -> F0 loaded, then 3C loaded next edge; wrap_cnt +1 and one host_ack.
4. mr pulsed asynchronously mid-HLOAD -> pe_n=1, cep=0, host_ack=0, wrap_cnt=0 immediately, without waiting for a cp edge.
5. run=0 mid-count at chain=F7 -> chain holds F7 and pe_n=1; run=1 again -> counting resumes at F8 after 1 cycle.
6. With CTR_LOAD_SCHED_ONESHOT_EN defined: run=1 -> single sweep F0..FF, then chain holds F0 with cep=0; run toggled 0->1 -> a second sweep occurs.
